// File: rtl/rom_dl_pkg.sv
// Shared types for the ROM download packer: FIFO entry layout and byte-enable codes.
// DL_ADDR_W sets the stored word-address width; keep it >= the packer's ADDR_W.
package rom_dl_pkg;

  localparam int DL_ADDR_W = 22;

  localparam logic [1:0] DS_LO = 2'b01;
  localparam logic [1:0] DS_HI = 2'b10;
  localparam logic [1:0] DS_W  = 2'b11;

  typedef struct packed {
    logic [DL_ADDR_W-1:0] addr;
    logic [15:0]          data;
    logic [1:0]           ds;
  } dl_entry_t;

  function automatic dl_entry_t mk_entry(input logic [DL_ADDR_W-1:0] addr,
                                         input logic [15:0]          data,
                                         input logic [1:0]           ds);
    dl_entry_t e;
    e.addr = addr;
    e.data = data;
    e.ds   = ds;
    return e;
  endfunction

endpackage

// File: rtl/rom_dl_fifo.sv
// Pending-write queue of dl_entry_t between the byte packer and the SDRAM request port.
// Latency: an entry pushed on one edge is at the head from the next cycle (no bypass).
// Backpressure: a push while full is ignored unless a pop happens in the same cycle.
module rom_dl_fifo
  import rom_dl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   push_vld,
  input  dl_entry_t              push_dat,
  input  logic                   pop_vld,
  output dl_entry_t              head_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  dl_entry_t   mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        wr_en;
  logic        rd_en;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign count    = wr_ptr - rd_ptr;
  assign rd_en    = pop_vld & ~empty;
  assign wr_en    = push_vld & (~full | rd_en);
  assign head_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/rom_dl_packer.sv
// ROM download byte stream to SDRAM word writes; ROM_DL_PACK_EN pairs even/odd bytes.
// Latency: strobe to ram_req toggle 2 cycles (3 for a staged odd byte when packing).
// Backpressure: toggle req/ack, one request outstanding; FIFO-full pushes drop and set overflow.
module rom_dl_packer
  import rom_dl_pkg::*;
#(
  parameter int ADDR_W     = 22,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_downl,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_din,
  output logic [1:0]        ram_ds,
  output logic              ram_we,
  output logic              ram_req,
  input  logic              ram_ack,
  output logic              rom_loaded,
  output logic              overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          downl_q;
  logic          dl_seen;
  logic          dl_rise;
  logic          port_idle;
  logic          pack_busy;
  logic          loaded_cond;
  logic          push_vld;
  logic          pop_vld;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  dl_entry_t     push_dat;
  dl_entry_t     head_dat;

  assign ram_we    = downl_q;
  assign dl_rise   = ioctl_downl & ~downl_q;
  assign port_idle = (ram_req == ram_ack);
  assign pop_vld   = port_idle & ~fifo_empty;

`ifdef ROM_DL_PACK_EN
  logic        dl_fall;
  logic        pend_vld;
  logic        pend_hit;
  logic        stg_vld;
  logic [23:0] pend_addr;
  logic [7:0]  pend_dat;
  dl_entry_t   pend_ent;
  dl_entry_t   stg_dat;

  assign dl_fall   = ~ioctl_downl & downl_q;
  assign pend_hit  = pend_vld & (pend_addr == ioctl_addr[24:1]);
  assign pend_ent  = mk_entry(DL_ADDR_W'(pend_addr[ADDR_W-1:0]), {8'h00, pend_dat}, DS_LO);
  assign pack_busy = pend_vld | stg_vld;

  // Strobes are >=2 cycles apart, so a staged odd byte never competes with a strobe push.
  always_comb begin
    push_vld = 1'b0;
    push_dat = pend_ent;
    if (stg_vld) begin
      push_vld = 1'b1;
      push_dat = stg_dat;
    end else if (ioctl_wr & ioctl_addr[0] & pend_hit) begin
      push_vld = 1'b1;
      push_dat = mk_entry(DL_ADDR_W'(ioctl_addr[ADDR_W:1]), {ioctl_dout, pend_dat}, DS_W);
    end else if (ioctl_wr | dl_fall) begin
      push_vld = pend_vld;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      pend_vld  <= 1'b0;
      pend_addr <= '0;
      pend_dat  <= '0;
      stg_vld   <= 1'b0;
      stg_dat   <= '0;
    end else begin
      stg_vld <= 1'b0;
      if (ioctl_wr & ~ioctl_addr[0]) begin
        pend_vld  <= 1'b1;
        pend_addr <= ioctl_addr[24:1];
        pend_dat  <= ioctl_dout;
      end else if (ioctl_wr) begin
        pend_vld <= 1'b0;
        if (!pend_hit) begin
          stg_vld <= 1'b1;
          stg_dat <= mk_entry(DL_ADDR_W'(ioctl_addr[ADDR_W:1]), {ioctl_dout, 8'h00}, DS_HI);
        end
      end else if (dl_fall) begin
        pend_vld <= 1'b0;
      end
    end
  end
`else
  assign pack_busy = 1'b0;

  always_comb begin
    push_vld = ioctl_wr;
    push_dat = mk_entry(DL_ADDR_W'(ioctl_addr[ADDR_W:1]), {ioctl_dout, ioctl_dout},
                        {ioctl_addr[0], ~ioctl_addr[0]});
  end
`endif

  rom_dl_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_vld  (pop_vld),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign loaded_cond = ~ioctl_downl & dl_seen & ~pack_busy & (fifo_count == '0) & port_idle;

  // Reset copies ram_ack into ram_req so an abandoned request is never reissued.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      ram_req    <= ram_ack;
      ram_addr   <= '0;
      ram_din    <= '0;
      ram_ds     <= '0;
      downl_q    <= 1'b0;
      dl_seen    <= 1'b0;
      rom_loaded <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      downl_q <= ioctl_downl;
      if (pop_vld) begin
        ram_req  <= ~ram_req;
        ram_addr <= ADDR_W'(head_dat.addr);
        ram_din  <= head_dat.data;
        ram_ds   <= head_dat.ds;
      end
      if (dl_rise) begin
        dl_seen    <= 1'b1;
        rom_loaded <= 1'b0;
        overflow   <= 1'b0;
      end else begin
        if (loaded_cond) rom_loaded <= 1'b1;
        if (push_vld & fifo_full & ~pop_vld) overflow <= 1'b1;
      end
    end
  end

endmodule

// File: doc/rom_dl_packer.md
# rom_dl_packer

Download-path stage between `data_io` and the SDRAM controller's ROM-upload port. It takes the byte stream produced during a ROM download (`ioctl_wr` strobes) and, when packing is enabled, merges even/odd byte pairs into 16-bit word writes. Writes are queued in a small FIFO and issued over the controller's toggle req/ack handshake. The block also generates the `rom_loaded` flag that gates core reset.

## Interface
Parameters:
- `ADDR_W`, 22: word-address width presented to SDRAM (`ioctl_addr[ADDR_W:1]`).
- `FIFO_DEPTH`, 4: pending-write entries; must be a power of two, ≥2.

Ports:
- `clk_sys` in 1: system clock, single clock domain.
- `reset_n` in 1: reset, synchronous, active-low.
- `ioctl_downl` in 1: download active.
- `ioctl_wr` in 1: one-cycle byte strobe; strobes are ≥2 cycles apart.
- `ioctl_addr` in 25: byte address of `ioctl_dout`.
- `ioctl_dout` in 8: download byte.
- `ram_addr` out ADDR_W: word address of the current request.
- `ram_din` out 16: write data; the even byte is on [7:0] and the odd byte is on [15:8].
- `ram_ds` out 2: byte enables; bit0 is the low/even byte and bit1 is the high/odd byte.
- `ram_we` out 1: equals `ioctl_downl` registered.
- `ram_req` out 1: request toggle.
- `ram_ack` in 1: acknowledge toggle from the SDRAM controller.
- `rom_loaded` out 1: the download has completed and every write has been acknowledged.
- `overflow` out 1: sticky flag; set when a write was dropped because the FIFO was full.

## Operation
- Entry format is {addr, data, ds}.
- **Pending register.** Holds at most one even byte.
- **Even-byte strobe** (`addr[0]`=0):
  - If a byte is already pending, push it alone with ds=01.
  - Then latch the new byte as pending.
- **Odd-byte strobe** (`addr[0]`=1):
  - If the pending byte's `addr[24:1]` matches, push the merged word with ds=11 and clear pending.
  - Otherwise, flush any pending byte with ds=01 in this cycle. Stage the odd byte (ds=10) and push it in the next cycle; the strobe spacing guarantees that free slot.
- **Download end.** When `ioctl_downl` falls, any pending byte is flushed with ds=01.
- **Download start.** When `ioctl_downl` rises, `rom_loaded` and `overflow` are cleared. The FIFO contents are kept.
- **Issue.** The request is idle when `ram_req`==`ram_ack`. When idle and the FIFO is non-empty:
  - Pop the head into the output registers (`ram_addr`/`ram_din`/`ram_ds`).
  - Toggle `ram_req` in the same clock edge.
  - Outputs hold stable until `ram_ack` equals `ram_req`.
- **Completion.** `rom_loaded` sets when all of the following hold: `ioctl_downl`=0, a download has occurred since reset, pending is clear, the staging slot is empty, the FIFO is empty, and `ram_req`==`ram_ack`.
- **Full FIFO.** A push into a full FIFO is dropped and sets `overflow`. A pop and a push in the same cycle are both allowed, including when the FIFO is full.

## Timing
- Reset values:
  - `ram_req` loads the current `ram_ack` (no phantom request).
  - `ram_addr`=0, `ram_din`=0, `ram_ds`=0, `ram_we`=0.
  - `rom_loaded`=0, `overflow`=0.
  - FIFO, pending and staging registers are empty.
- Reset mid-transfer discards all queued data. A request already outstanding is abandoned, not reissued.
- Latency from the strobe to `ram_req` toggling, with the FIFO empty and the port idle:
  - Merged or flushed entry: 2 cycles (push, then pop/issue).
  - Staged odd byte: 3 cycles.
- At most one request is outstanding. The next issue comes no earlier than the cycle after ack equality is observed.
- `rom_loaded` asserts 1 cycle after the completion condition holds.
- FIFO pointers are `$clog2(FIFO_DEPTH)+1` bits and wrap naturally. Full is when the MSBs differ and the remaining bits are equal.

## Configuration
- `ROM_DL_PACK_EN` defined: even/odd pairing as described above.
- `ROM_DL_PACK_EN` undefined:
  - Each strobe pushes one entry directly.
  - Entry fields: `ds` = {addr[0], ~addr[0]}, `din` = {dout, dout}.
  - The pending and staging logic is absent.
  - Latency is 2 cycles.

## Structure
- Package `rom_dl_pkg`:
  - `dl_entry_t` packed struct {`logic [ADDR_W-1:0] addr; logic [15:0] data; logic [1:0] ds;`}.
  - Constants `DS_LO`=2'b01, `DS_HI`=2'b10, `DS_W`=2'b11.
- Sub-module `rom_dl_fifo`: synchronous FIFO of `dl_entry_t` with push, pop, full, empty and count. The packing, handshake and loaded-flag logic live in `rom_dl_packer`.

## Test plan
- Packed pair: strobe addr 0x0100 with data 0x12, then addr 0x0101 with data 0x34 → one request with `ram_addr`=0x080, `ram_din`=0x3412, `ram_ds`=11.
- Lone odd byte: strobe addr 0x0203 with data 0xAA and nothing pending → request with `ram_addr`=0x101, ds=10, `din`[15:8]=0xAA, toggling 3 cycles after the strobe.
- Non-matching pair: strobe addr 0x0010, then addr 0x0021 → two requests, ds=01 at word 0x008 followed by ds=10 at word 0x010.
- Tail flush and loaded: strobe addr 0x0400, then drop `ioctl_downl` → one ds=01 request; after `ram_ack` toggles, `rom_loaded`=1 one cycle later.
- Backpressure and overflow: with `FIFO_DEPTH`=4 and `ram_ack` held, send 12 bytes as packed pairs (6 entries).
  - 1 entry issues and 4 queue; the 6th sets `overflow`=1.
  - Releasing ack delivers exactly 5 words, in order.
- Reset mid-transfer: pull `reset_n` low for 1 cycle with 3 entries queued and `ram_ack`=1 → `ram_req`=1, no further requests, `rom_loaded`=0.
